// File: rtl/iob_cache_write_buffer_channel.sv
// rtl/iob_cache_write_buffer_channel.sv - coalescing write buffer between a narrow front end and a wide back end
module iob_cache_write_buffer_channel #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 64,
    parameter int DEPTH     = 4,
    parameter int COALESCE  = 1
) (
    input  logic                           reset,
    input  logic                           clk_i,
    input  logic                           valid,
    input  logic [FE_ADDR_W-1:0]           addr,
    input  logic [FE_DATA_W/8-1:0]         wstrb,
    input  logic [FE_DATA_W-1:0]           wdata,
    output logic                           ready,
    output logic [BE_ADDR_W-1:0]           be_addr,
    output logic                           be_valid,
    input  logic                           be_ack,
    output logic [BE_DATA_W-1:0]           be_wdata,
    output logic [BE_DATA_W/8-1:0]         be_wstrb,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         level
);
    localparam int FE_NBYTES = FE_DATA_W / 8;
    localparam int BE_NBYTES = BE_DATA_W / 8;
    localparam int FE_OFF_W  = $clog2(FE_NBYTES);
    localparam int BE_OFF_W  = $clog2(BE_NBYTES);
    localparam int RATIO     = BE_DATA_W / FE_DATA_W;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;

    logic [BE_ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [BE_ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [BE_DATA_W-1:0] ent_data_q [DEPTH];
    logic [BE_DATA_W-1:0] ent_data_d [DEPTH];
    logic [BE_NBYTES-1:0] ent_strb_q [DEPTH];
    logic [BE_NBYTES-1:0] ent_strb_d [DEPTH];

    logic [BE_ADDR_W-1:0] addr_ext;
    logic [BE_ADDR_W-1:0] in_addr;
    logic [BE_DATA_W-1:0] in_data;
    logic [BE_NBYTES-1:0] in_strb;
    logic [PTR_W-1:0]     tail_ptr;
    logic                 unused_addr_bits;
    logic                 full, hit, strb_nz, accept, alloc, merge, pop;

    // Incoming write mapped onto a back-end word: aligned address, replicated data, lane-shifted strobe
    assign addr_ext         = BE_ADDR_W'(addr);
    assign in_addr          = {addr_ext[BE_ADDR_W-1:BE_OFF_W], {BE_OFF_W{1'b0}}};
    assign in_data          = {RATIO{wdata}};
    assign unused_addr_bits = ^addr_ext[BE_OFF_W-1:0];

    if (RATIO > 1) begin : g_align
        logic [BE_OFF_W-FE_OFF_W-1:0] word_align;
        assign word_align = addr_ext[BE_OFF_W-1:FE_OFF_W];
        assign in_strb    = BE_NBYTES'(wstrb) << {word_align, {FE_OFF_W{1'b0}}};
    end else begin : g_noalign
        assign in_strb = wstrb;
    end

    // Handshake decode; the head entry is never a merge target because hit needs two entries
    assign tail_ptr = wr_ptr_q - PTR_W'(1);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign hit      = (COALESCE != 0) && (level_q >= LVL_W'(2)) && (in_addr == ent_addr_q[tail_ptr]);
    assign strb_nz  = |wstrb;
    assign ready    = ~full | hit | ~strb_nz;
    assign accept   = valid & ready;
    assign alloc    = accept & ~hit & strb_nz;
    assign merge    = accept & hit & strb_nz;
    assign be_valid = (level_q != '0);
    assign pop      = be_valid & be_ack;

    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign be_addr  = ent_addr_q[rd_ptr_q];
    assign be_wdata = ent_data_q[rd_ptr_q];
    assign be_wstrb = be_valid ? ent_strb_q[rd_ptr_q] : '0;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (alloc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({alloc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Entry storage next-state: allocate at the write pointer or merge bytes into the tail
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_strb_d = ent_strb_q;
        if (alloc) begin
            ent_addr_d[wr_ptr_q] = in_addr;
            ent_data_d[wr_ptr_q] = in_data;
            ent_strb_d[wr_ptr_q] = in_strb;
        end
        if (merge) begin
            for (int i = 0; i < BE_NBYTES; i++) begin
                if (in_strb[i]) ent_data_d[tail_ptr][i*8 +: 8] = in_data[i*8 +: 8];
            end
            ent_strb_d[tail_ptr] = ent_strb_q[tail_ptr] | in_strb;
        end
    end

    // Control state, cleared asynchronously so the back end sees no stale request
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry payload registers; contents are only observed while counted by level
    always_ff @(posedge clk_i) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_strb_q <= ent_strb_d;
    end
endmodule

// File: tb/tb_iob_cache_write_buffer_channel.sv
// tb/tb_iob_cache_write_buffer_channel.sv - directed vector bench for iob_cache_write_buffer_channel
module tb_iob_cache_write_buffer_channel;
    logic        clk_i = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        be_ack;

    logic        ready, be_valid, empty;
    logic [31:0] be_addr;
    logic [63:0] be_wdata;
    logic [7:0]  be_wstrb;
    logic [2:0]  level;

    logic        unused_nc_ready, nc_be_valid, nc_empty;
    logic [31:0] nc_be_addr;
    logic [63:0] unused_nc_wdata;
    logic [7:0]  nc_be_wstrb;
    logic [2:0]  nc_level;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    iob_cache_write_buffer_channel dut (
        .reset(reset), .clk_i(clk_i), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .ready(ready), .be_addr(be_addr), .be_valid(be_valid), .be_ack(be_ack),
        .be_wdata(be_wdata), .be_wstrb(be_wstrb), .empty(empty), .level(level)
    );

    iob_cache_write_buffer_channel #(.COALESCE(0)) dut_nc (
        .reset(reset), .clk_i(clk_i), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .ready(unused_nc_ready), .be_addr(nc_be_addr), .be_valid(nc_be_valid), .be_ack(be_ack),
        .be_wdata(unused_nc_wdata), .be_wstrb(nc_be_wstrb), .empty(nc_empty), .level(nc_level)
    );

    typedef struct {
        logic        vld;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        ack;
        logic        rdy;
        logic [2:0]  lvl;
        logic        bv;
        logic [31:0] ba;
        logic [7:0]  bs;
        logic [63:0] bd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic ack);
        valid  = v;
        addr   = a;
        wstrb  = s;
        wdata  = d;
        be_ack = ack;
    endtask

    // Apply at negedge, clock once, return to the next negedge
    task automatic cycle(input logic v, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic ack);
        drive(v, a, s, d, ack);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h104, 4'hF, 32'hAABBCCDD, 1'b0, 1'b1, 3'd1, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[1]  = '{1'b1, 32'h108, 4'hF, 32'h11111111, 1'b0, 1'b1, 3'd2, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[2]  = '{1'b1, 32'h10C, 4'h3, 32'h22222222, 1'b0, 1'b1, 3'd2, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[3]  = '{1'b1, 32'h200, 4'hF, 32'h33333333, 1'b0, 1'b1, 3'd3, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[4]  = '{1'b1, 32'h300, 4'h0, 32'h99999999, 1'b0, 1'b1, 3'd3, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[5]  = '{1'b1, 32'h400, 4'hF, 32'h44444444, 1'b0, 1'b1, 3'd4, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[6]  = '{1'b1, 32'h500, 4'hF, 32'h55555555, 1'b0, 1'b0, 3'd4, 1'b1, 32'h100, 8'hF0, 64'hAABBCCDD_AABBCCDD};
        vecs[7]  = '{1'b1, 32'h500, 4'hF, 32'h55555555, 1'b1, 1'b0, 3'd3, 1'b1, 32'h108, 8'h3F, 64'h11112222_11111111};
        vecs[8]  = '{1'b1, 32'h500, 4'hF, 32'h55555555, 1'b0, 1'b1, 3'd4, 1'b1, 32'h108, 8'h3F, 64'h11112222_11111111};
        vecs[9]  = '{1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b1, 3'd3, 1'b1, 32'h200, 8'h0F, 64'h33333333_33333333};
        vecs[10] = '{1'b1, 32'h404, 4'h1, 32'h66666666, 1'b1, 1'b1, 3'd3, 1'b1, 32'h400, 8'h0F, 64'h44444444_44444444};
        vecs[11] = '{1'b1, 32'h400, 4'h2, 32'h77777777, 1'b1, 1'b1, 3'd2, 1'b1, 32'h500, 8'h0F, 64'h55555555_55555555};
        vecs[12] = '{1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 32'h400, 8'h12, 64'h66666666_66667766};
        vecs[13] = '{1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b1, 3'd0, 1'b0, 32'h0,   8'h00, 64'h0};
        vecs[14] = '{1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 1'b1, 3'd0, 1'b0, 32'h0,   8'h00, 64'h0};

        reset = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        #2;
        chk("reset_empty", empty, 1);
        chk("reset_be_valid", be_valid, 0);
        chk("reset_ready", ready, 1);
        chk("reset_level", level, 0);
        chk("reset_be_wstrb", be_wstrb, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].vld, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].ack);
            #1;
            chk($sformatf("v%0d_ready", i), ready, vecs[i].rdy);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("v%0d_be_valid", i), be_valid, vecs[i].bv);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].lvl == 0);
            chk($sformatf("v%0d_be_wstrb", i), be_wstrb, vecs[i].bs);
            if (vecs[i].bv) begin
                chk($sformatf("v%0d_be_addr", i), be_addr, vecs[i].ba);
                chk($sformatf("v%0d_be_wdata", i), be_wdata, vecs[i].bd);
            end
            @(negedge clk_i);
        end

        // Merge versus no-merge on the same stream
        reset = 1'b1;
        @(negedge clk_i);
        reset = 1'b0;
        cycle(1'b1, 32'h100, 4'hF, 32'h01010101, 1'b0);
        @(negedge clk_i);
        cycle(1'b1, 32'h200, 4'hF, 32'h02020202, 1'b0);
        @(negedge clk_i);
        cycle(1'b1, 32'h204, 4'h3, 32'h03030303, 1'b0);
        chk("coal_level", level, 2);
        chk("nocoal_level", nc_level, 3);
        @(negedge clk_i);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("coal_tail_addr", be_addr, 32'h200);
        chk("coal_tail_strb", be_wstrb, 8'h3F);
        chk("nocoal_head_addr", nc_be_addr, 32'h200);
        chk("nocoal_head_strb", nc_be_wstrb, 8'h0F);
        chk("nocoal_level_after_pop", nc_level, 2);

        // Fill to three entries, then reset asynchronously in the middle of a transfer
        @(negedge clk_i);
        cycle(1'b1, 32'h300, 4'hF, 32'h04040404, 1'b0);
        @(negedge clk_i);
        cycle(1'b1, 32'h400, 4'hF, 32'h05050505, 1'b0);
        chk("pre_reset_level", level, 3);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_empty", empty, 1);
        chk("async_reset_be_valid", be_valid, 0);
        chk("async_reset_level", level, 0);
        chk("async_reset_ready", ready, 1);
        chk("async_reset_nc_empty", nc_empty, 1);
        @(negedge clk_i);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("post_reset_be_valid_%0d", c), be_valid, 0);
            chk($sformatf("post_reset_nc_be_valid_%0d", c), nc_be_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
